// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM demodulator.
package pwm_pkg;

  typedef enum logic {
    StHunt  = 1'b0,
    StTrack = 1'b1
  } pwm_state_e;

  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefPeriod = 256;

  // Largest value representable in w bits; w is expected to stay below 32.
  function automatic int unsigned max_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// Input synchroniser for the PWM pin plus rising-edge detect on the synchronised stream.
module pwm_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm,
  output logic pwm_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~prev_q;

endmodule

// File: rtl/pwm_demodulator.sv
// Recovers the per-period duty sample from a PWM stream by counting high clocks per period.
// Define PWM_DEMOD_AVG_EN to output the running mean of the last four period results.
module pwm_demodulator
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned PERIOD      = DefPeriod,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm,
  output logic [CNT_W-1:0] sample,
  output logic             sample_valid,
  output logic             locked,
  output logic             phase_err
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W:0]   MaxVal  = (CNT_W+1)'(max_val(CNT_W));

  logic pwm_s, rise;

  pwm_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .pwm  (pwm),
    .pwm_s(pwm_s),
    .rise (rise)
  );

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             period_done;
  logic [CNT_W:0]   raw_sum;
  logic [CNT_W-1:0] raw;

  // pcnt_q is the index of the current pwm_s cycle within its period; hcnt_q counts
  // the high cycles before it, so the rise cycle itself leaves pcnt=1, hcnt=1 behind.
  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    hcnt_d      = hcnt_q;
    err_d       = 1'b0;
    period_done = 1'b0;
    raw_sum     = {1'b0, hcnt_q} + (CNT_W+1)'(pwm_s);
    raw         = (raw_sum > MaxVal) ? MaxVal[CNT_W-1:0] : raw_sum[CNT_W-1:0];
    unique case (state_q)
      StHunt: begin
        if (rise) begin
          state_d = StTrack;
          pcnt_d  = CNT_W'(1);
          hcnt_d  = CNT_W'(1);
        end
      end
      StTrack: begin
        if (rise && (pcnt_q != '0)) begin
          err_d  = 1'b1;
          pcnt_d = CNT_W'(1);
          hcnt_d = CNT_W'(1);
        end else if (pcnt_q == LastIdx) begin
          period_done = 1'b1;
          pcnt_d      = '0;
          hcnt_d      = '0;
        end else begin
          pcnt_d = pcnt_q + CNT_W'(1);
          hcnt_d = hcnt_q + CNT_W'(pwm_s);
        end
      end
      default: state_d = StHunt;
    endcase
  end

`ifdef PWM_DEMOD_AVG_EN
  logic [2:0][CNT_W-1:0] hist_q, hist_d;
  logic [1:0]            fill_q, fill_d;
  logic [CNT_W+1:0]      avg_sum;

  // hist_q holds the three previous raw results; the current raw value is the fourth.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    avg_sum  = (CNT_W+2)'(raw) + (CNT_W+2)'(hist_q[0]) + (CNT_W+2)'(hist_q[1])
             + (CNT_W+2)'(hist_q[2]);
    if (err_d || (state_q == StHunt)) begin
      fill_d = '0;
    end else if (period_done) begin
      hist_d = {hist_q[1:0], raw};
      if (fill_q == 2'd3) begin
        valid_d  = 1'b1;
        sample_d = avg_sum[CNT_W+1:2];
      end else begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
`else
  always_comb begin
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (period_done) begin
      sample_d = raw;
      valid_d  = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StHunt;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign locked       = (state_q == StTrack);
  assign phase_err    = err_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Bench for pwm_demodulator: drives whole PWM periods and predicts each strobe from the duty.
module tb_pwm_demodulator;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PERIOD = 256;
  localparam int unsigned SYNC   = 2;
  localparam int          MAXV   = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm;
  logic [CNT_W-1:0] sample;
  logic             sample_valid;
  logic             locked;
  logic             phase_err;

  pwm_demodulator #(
    .CNT_W      (CNT_W),
    .PERIOD     (PERIOD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm         (pwm),
    .sample      (sample),
    .sample_valid(sample_valid),
    .locked      (locked),
    .phase_err   (phase_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   last_k   = 0;
  int   first_k  = 0;
  int   lock_k   = 0;
  int   last_exp = 0;
  int   lock_cyc = -1;
  bit   mon_en   = 1'b0;
  logic prev_locked = 1'b0;
  exp_t exp_q[$];
  int   err_q[$];
  int   raw_hist[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Monitor: every strobe and phase error must match the next predicted one exactly.
  always @(negedge clk) begin
    if (mon_en) begin
      if (locked === 1'b1 && prev_locked !== 1'b1 && lock_cyc < 0) lock_cyc = cyc;
      prev_locked = locked;
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("missed_strobe", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        check("missed_phase_err", cyc, err_q[0]);
        void'(err_q.pop_front());
      end
      if (sample_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_cyc", cyc, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_cyc", cyc, mon_e.cyc);
          check("sample", sample, mon_e.val);
          last_exp = mon_e.val;
        end
      end else begin
        check("sample_hold", sample, last_exp);
      end
      if (phase_err !== 1'b0) begin
        if (err_q.size() == 0) check("unexpected_phase_err_cyc", cyc, -1);
        else check("phase_err_cyc", cyc, err_q.pop_front());
      end
    end
  end

  // Reference: a complete period's result is its high count clipped to the sample range;
  // with averaging the strobe carries the floor mean of the last four such results.
  task automatic push_raw(input int high, input int k_end);
    int raw;
    raw = (high > MAXV) ? MAXV : high;
`ifdef PWM_DEMOD_AVG_EN
    raw_hist.push_back(raw);
    if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    if (raw_hist.size() == 4)
      exp_q.push_back('{k_end + SYNC + 1,
                        (raw_hist[0] + raw_hist[1] + raw_hist[2] + raw_hist[3]) / 4});
`else
    exp_q.push_back('{k_end + SYNC + 1, raw});
`endif
  endtask

  task automatic tick(input logic v);
    @(negedge clk);
    #1;
    pwm    = v;
    last_k = cyc;
  endtask

  task automatic period(input int high, input int total, input bit want_strobe,
                        input bit err_start);
    for (int i = 0; i < total; i++) begin
      tick(i < high);
      if (i == 0) begin
        first_k = last_k;
        if (err_start) begin
          err_q.push_back(last_k + SYNC + 1);
          raw_hist.delete();
        end
      end
    end
    if (want_strobe) push_raw(high, last_k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    pwm      = 1'b0;
    last_exp = 0;
    lock_cyc = -1;
    raw_hist.delete();
    @(negedge clk);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_phase_err", phase_err, 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int duties[5];
    duties = '{10, 200, 0, 256, 128};
    reset  = 1'b1;
    pwm    = 1'b0;
    repeat (3) @(negedge clk);
    check("init_sample", sample, 0);
    check("init_locked", locked, 0);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // 50% stream from HUNT
    period(128, PERIOD, 1'b1, 1'b0);
    lock_k = first_k;
    repeat (3) period(128, PERIOD, 1'b1, 1'b0);
    check("lock_latency", lock_cyc, lock_k + SYNC + 1);

    // duty walk including both extremes
    foreach (duties[i]) period(duties[i], PERIOD, 1'b1, 1'b0);

    // random duties over the full range
    repeat (8) period($urandom_range(0, PERIOD), PERIOD, 1'b1, 1'b0);

    // rise at pcnt=100 realigns the period and drops the truncated result
    period(128, PERIOD, 1'b1, 1'b0);
    period(50, 100, 1'b0, 1'b0);
    period(128, PERIOD, 1'b1, 1'b1);
    period(128, PERIOD, 1'b1, 1'b0);
    check("locked_after_realign", locked, 1);

    // ramp of raw values from a clean start
    repeat (4) tick(1'b0);
    do_reset();
    for (int i = 0; i < 5; i++) period(100 + 4 * i, PERIOD, 1'b1, 1'b0);

    // reset part-way through a period, then relock
    for (int i = 0; i < 52; i++) tick(1'b1);
    do_reset();
    repeat (20) tick(1'b0);
    period(128, PERIOD, 1'b1, 1'b0);
    lock_k = first_k;
    period(128, PERIOD, 1'b1, 1'b0);
    check("relock_latency", lock_cyc, lock_k + SYNC + 1);

    // no edge at all keeps the block hunting
    repeat (4) tick(1'b0);
    do_reset();
    repeat (1000) tick(1'b0);
    check("hunt_locked", locked, 0);
    check("hunt_never_locked", lock_cyc, -1);

    repeat (8) tick(1'b0);
    check("strobes_drained", exp_q.size(), 0);
    check("phase_errs_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
Receive-side counterpart of the sine PWM generator. Recovers the 8-bit sample that drove each PWM period by counting high clocks per period, so a generated sine can be checked or looped back in hardware. Sits at the far end of the PWM link, on the same clock as the generator, and feeds sample capture or a comparator.

Parameters:
CNT_W, 8, sample and period-counter width.
PERIOD, 256, clocks per PWM period. Must be ≤ 2**CNT_W.
SYNC_STAGES, 2, input synchroniser depth. Must be ≥ 2.

Ports:
clk  input  1  system clock; all logic rising-edge.
reset  input  1  synchronous, active-high reset.
pwm  input  1  PWM stream from the generator.
sample  output  CNT_W  recovered duty value for the last complete period.
sample_valid  output  1  one-cycle strobe; sample is updated in the same cycle.
locked  output  1  high while period phase is established.
phase_err  output  1  one-cycle pulse on a rising edge at an unexpected phase.

Behaviour:
- Reset: sample=0, sample_valid=0, locked=0, phase_err=0, counters=0, synchroniser flops=0, state=HUNT. Reset has priority over all other activity and may be asserted mid-period; the partial period is discarded.
- Synchroniser: pwm passes through SYNC_STAGES flops to give pwm_s. A rise is pwm_s=1 while the previous pwm_s=0. All timing below is in the pwm_s domain, which lags pin pwm by SYNC_STAGES cycles.
- State HUNT: locked=0, no strobes. On a rise, go to TRACK with pcnt=0 and hcnt=1, because the edge cycle counts as high.
- State TRACK: locked=1. Each cycle pcnt increments, and hcnt increments when pwm_s=1.
- End of period: at pcnt==PERIOD-1, the value hcnt + pwm_s (CNT_W+1 bits) is saturated to 2**CNT_W-1 and registered into sample. sample_valid=1 for exactly that following cycle. pcnt wraps to 0 and hcnt reloads with the current-cycle pwm_s.
- Rise at pcnt==0 is a normal period start.
- Rise at pcnt≠0 is a phase jump: phase_err pulses for one cycle, the period realigns (pcnt=0, hcnt=1), and no sample_valid is issued for the truncated period. locked stays 1.
- Duty 0 (no rise) and duty 100% (no rise) are legal in TRACK. They yield sample=0 and sample=2**CNT_W-1 respectively, with no error.
- Latency: sample_valid is asserted 1 cycle after the last pwm_s cycle of a period, i.e. SYNC_STAGES+1 cycles after the last pin cycle.
- sample holds its value between strobes.

Optional Feature:
PWM_DEMOD_AVG_EN.
- Defined: each raw period result enters a 4-deep history. sample is the sum of the last 4 raw values (CNT_W+2 bits) >> 2, truncated. sample_valid is suppressed until 4 raw values have been collected since entering TRACK or since the last realign; the fill count clears on reset, HUNT or phase_err.
- Undefined: sample is the raw per-period value, and the history, adder and fill count are not instantiated.

Decomposition:
- Package pwm_pkg holds:
  - state encoding: HUNT=1'b0, TRACK=1'b1;
  - default CNT_W and PERIOD constants;
  - the saturation max-value function.
- One sub-module is natural: pwm_sync (SYNC_STAGES flop chain plus rise detect; outputs pwm_s and rise).
- Counters, FSM and the optional averager stay in pwm_demodulator.

Test Plan:
- Reset, then a 50% stream (128 high / 128 low per 256-clock period) → locked rises SYNC_STAGES+1 cycles after the first pin edge. Each subsequent period gives sample_valid with sample=128, and phase_err never pulses.
- After lock, duty walks 10, 200, 0, then 256 (constant high) → samples 10, 200, 0, 255 (saturated) in order, with no phase_err.
- After lock, a glitch forces a rise at pcnt=100 → phase_err one-cycle pulse, no sample_valid for that period, next strobe 256 cycles later with the correct value.
- reset asserted for one cycle at pcnt=50 → next cycle all outputs are 0 and state is HUNT. The next rise relocks and the first strobe comes a full period later.
- Before any rise (pwm held 0 after reset) → locked=0 and no sample_valid for 1000 cycles.
- With PWM_DEMOD_AVG_EN, raw values 100, 104, 108, 112, 116 → first strobe only after the 4th period with sample=106, then 110.
